// File: rtl/kb_field_editor_if.sv
// Port bundle between the PS/2 byte buffer / PicoBlaze port bus and kb_field_editor.
// The slave modport is the editor's view of the bundle; the master modport is the driver's.
interface kb_field_editor_if #(
  parameter int DIGITS = 2,
  parameter int ADDR_W = 8
);
  logic [15:0]         i_kb_buffer;
  logic                i_read_strobe;
  logic [1:0]          i_data_select;
  logic [ADDR_W-1:0]   o_address;
  logic [4*DIGITS-1:0] o_data;
  logic [7:0]          o_commit;
  logic                o_busy;

  modport master (
    output i_kb_buffer, i_read_strobe, i_data_select,
    input  o_address, o_data, o_commit, o_busy
  );

  modport slave (
    input  i_kb_buffer, i_read_strobe, i_data_select,
    output o_address, o_data, o_commit, o_busy
  );
endinterface

// File: rtl/kb_field_editor.sv
// PS/2 scancode field editor: picks a register group, tabs through fields, shifts in BCD
// digits and holds {address, data} pending until the PicoBlaze acknowledges the commit.
//   state  | meaning
//   S_IDLE | waiting for a group select (F1/F2/F3) or ring write (F11/F12)
//   S_EDIT | shifting digits into the selected field, inactivity timer running
//   S_PEND | commit flag raised, address/data frozen until acknowledged
module kb_field_editor #(
  parameter int          DIGITS     = 2,
  parameter int          ADDR_W     = 8,
  parameter int          FIELDS     = 3,
  parameter int          DATE_BASE  = 22,
  parameter int          CLOCK_BASE = 19,
  parameter int          TIMER_BASE = 25,
  parameter int          RING_ADDR  = 28,
  parameter int          RING_ON    = 8,
  parameter logic [1:0]  ACK_SEL    = 2'b10,
  parameter int          TIMEOUT    = 1000000000,
  parameter int          TO_W       = 30
) (
  input  logic               i_clk,
  input  logic               i_rst,
  kb_field_editor_if.slave   bus
);
  localparam int DW    = 4 * DIGITS;
  localparam int IDX_W = (FIELDS > 1) ? $clog2(FIELDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_PEND} state_t;

  state_t            r_state,   w_state_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [ADDR_W-1:0] r_base,    w_base_nxt;
  logic [DW-1:0]     r_data,    w_data_nxt;
  logic [IDX_W-1:0]  r_idx,     w_idx_nxt;
  logic [TO_W-1:0]   r_timer,   w_timer_nxt;
  logic [15:0]       r_kb_prev, w_kb_prev_nxt;

  logic [7:0] w_hi, w_lo;
  logic       w_event, w_make, w_esc, w_ack;
  logic       w_grp_hit, w_ring_hit, w_digit_hit;
  logic [ADDR_W-1:0] w_grp_base;
  logic [DW-1:0]     w_ring_data;
  logic [3:0]        w_digit;

  assign w_hi    = bus.i_kb_buffer[15:8];
  assign w_lo    = bus.i_kb_buffer[7:0];
  assign w_event = (bus.i_kb_buffer != r_kb_prev);
  assign w_make  = w_event && (w_hi != 8'hF0) && (w_hi != 8'hE0);
  assign w_esc   = w_event && (w_hi == 8'hF0) && (w_lo == 8'h76);
  assign w_ack   = bus.i_read_strobe && (bus.i_data_select == ACK_SEL);

  always_comb begin
    w_grp_hit   = 1'b1;
    w_grp_base  = '0;
    w_ring_hit  = 1'b1;
    w_ring_data = '0;
    w_digit_hit = 1'b1;
    w_digit     = 4'd0;
    case (w_lo)
      8'h05:   w_grp_base = ADDR_W'(DATE_BASE);
      8'h06:   w_grp_base = ADDR_W'(CLOCK_BASE);
      8'h04:   w_grp_base = ADDR_W'(TIMER_BASE);
      default: w_grp_hit  = 1'b0;
    endcase
    case (w_lo)
      8'h78:   w_ring_data = DW'(RING_ON);
      8'h07:   w_ring_data = '0;
      default: w_ring_hit  = 1'b0;
    endcase
    case (w_lo)
      8'h45:   w_digit = 4'd0;
      8'h16:   w_digit = 4'd1;
      8'h1E:   w_digit = 4'd2;
      8'h26:   w_digit = 4'd3;
      8'h25:   w_digit = 4'd4;
      8'h2E:   w_digit = 4'd5;
      8'h36:   w_digit = 4'd6;
      8'h3D:   w_digit = 4'd7;
      8'h3E:   w_digit = 4'd8;
      8'h46:   w_digit = 4'd9;
      default: w_digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_base_nxt    = r_base;
    w_data_nxt    = r_data;
    w_idx_nxt     = r_idx;
    w_timer_nxt   = r_timer;
    w_kb_prev_nxt = w_event ? bus.i_kb_buffer : r_kb_prev;

    if (w_esc) begin
      // Clearing kb_prev lets the very same key sequence be detected again.
      w_state_nxt   = S_IDLE;
      w_addr_nxt    = '0;
      w_base_nxt    = '0;
      w_data_nxt    = '0;
      w_idx_nxt     = '0;
      w_timer_nxt   = '0;
      w_kb_prev_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_make && w_ring_hit) begin
            w_state_nxt = S_PEND;
            w_addr_nxt  = ADDR_W'(RING_ADDR);
            w_data_nxt  = w_ring_data;
          end else if (w_make && w_grp_hit) begin
            w_state_nxt = S_EDIT;
            w_addr_nxt  = w_grp_base;
            w_base_nxt  = w_grp_base;
            w_data_nxt  = '0;
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
          end
        end
        S_EDIT: begin
          if (w_event) begin
            w_timer_nxt = '0;
            if (w_make) begin
              if (w_ring_hit) begin
                w_state_nxt = S_PEND;
                w_addr_nxt  = ADDR_W'(RING_ADDR);
                w_data_nxt  = w_ring_data;
              end else if (w_grp_hit) begin
                w_addr_nxt = w_grp_base;
                w_base_nxt = w_grp_base;
                w_data_nxt = '0;
                w_idx_nxt  = '0;
              end else if (w_digit_hit) begin
                w_data_nxt = (r_data << 4) | DW'(w_digit);
              end else if (w_lo == 8'h66) begin
                w_data_nxt = r_data >> 4;
              end else if (w_lo == 8'h0D) begin
                if (r_idx == IDX_W'(FIELDS - 1)) begin
                  w_idx_nxt  = '0;
                  w_addr_nxt = r_base;
                end else begin
                  w_idx_nxt  = r_idx + 1'b1;
                  w_addr_nxt = r_addr - 1'b1;
                end
              end else if (w_lo == 8'h5A) begin
                w_state_nxt = S_PEND;
              end
            end
          end else if (r_timer == TO_W'(TIMEOUT - 1)) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_base_nxt  = '0;
            w_data_nxt  = '0;
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        S_PEND: begin
          // A key event arriving with the ack is consumed through kb_prev but dropped.
          if (w_ack) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_base_nxt  = '0;
            w_data_nxt  = '0;
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
          w_base_nxt  = '0;
          w_data_nxt  = '0;
          w_idx_nxt   = '0;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_base    <= '0;
      r_data    <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_kb_prev <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_base    <= w_base_nxt;
      r_data    <= w_data_nxt;
      r_idx     <= w_idx_nxt;
      r_timer   <= w_timer_nxt;
      r_kb_prev <= w_kb_prev_nxt;
    end
  end

  assign bus.o_address = r_addr;
  assign bus.o_data    = r_data;
  assign bus.o_commit  = {7'b0, (r_state == S_PEND)};
  assign bus.o_busy    = (r_state != S_IDLE);
endmodule
